// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// next-pc selection codes and the default widths/values.
package fetch_unit_pkg;

   localparam int PC_WIDTH_DEF = 10;
   localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

   // Fetch sequencer states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

   // Next-pc selection for the pc generator.
   typedef enum logic [1:0] {
      PC_KEEP = 2'd0,
      PC_INC  = 2'd1,
      PC_LOAD = 2'd2
   } pc_sel_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus.
// Handshake: the fetch side raises oIM_req with oIM_addr and keeps the
// address stable until a cycle in which iIM_ack=1; iIM_rdata is valid only
// in that ack cycle, and the request may stay high for the next address.
interface fetch_unit_if #(
   parameter int PC_WIDTH = 10
);
   logic                oIM_req;
   logic [PC_WIDTH-1:0] oIM_addr;
   logic                iIM_ack;
   logic [31:0]         iIM_rdata;

   modport master (
      output oIM_req,
      output oIM_addr,
      input  iIM_ack,
      input  iIM_rdata
   );

   modport slave (
      input  oIM_req,
      input  oIM_addr,
      output iIM_ack,
      output iIM_rdata
   );
endinterface

// File: rtl/fetch_pc_gen.sv
// Program counter register with its next-pc mux (keep / +1 / load target).
// Increment wraps modulo 2^PC_WIDTH.
module fetch_pc_gen
   import fetch_unit_pkg::*;
#(
   parameter int                  PC_WIDTH = PC_WIDTH_DEF,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clock,
   input  logic                reset_n,
   input  pc_sel_e             pc_sel,
   input  logic [PC_WIDTH-1:0] target,
   output logic [PC_WIDTH-1:0] pc
);

   logic [PC_WIDTH-1:0] pc_next;

   // Select the next program counter value.
   always_comb begin
      pc_next = pc;
      case (pc_sel)
         PC_INC:  pc_next = pc + PC_WIDTH'(1);
         PC_LOAD: pc_next = target;
         default: pc_next = pc;
      endcase
   end

   // Program counter register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_next;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequences requests to instruction memory,
// captures the returned word with its pc for the REG1 wall, stalls on
// hazard and redirects on a taken branch (raising the wall flushes).
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                  PC_WIDTH = PC_WIDTH_DEF,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
   parameter logic [31:0]         NOP_WORD = NOP_WORD_DEF
) (
   input  logic                clock,
   input  logic                reset_n,
   fetch_unit_if.master        im,
   input  logic                iEX_branch_taken,
   input  logic [PC_WIDTH-1:0] iEX_branch_target,
   input  logic                hazard,
   output logic [31:0]         oIF_instruction,
   output logic [PC_WIDTH-1:0] oIF_current_pc,
   output logic                do_flush_REG1,
   output logic                do_flush_REG2,
   output fetch_state_e        dbg_state
);

   fetch_state_e        state;
   fetch_state_e        state_next;
   pc_sel_e             pc_sel;
   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] drain_addr;
   logic [31:0]         inst_q;
   logic [PC_WIDTH-1:0] pc_q;
   logic                valid;

   logic                redirect;
   logic                capture;
   logic                clear_valid;
   logic                drain_load;
   logic                req;
   logic [PC_WIDTH-1:0] addr;

   fetch_pc_gen #(
      .PC_WIDTH (PC_WIDTH),
      .RESET_PC (RESET_PC)
   ) u_pc_gen (
      .clock   (clock),
      .reset_n (reset_n),
      .pc_sel  (pc_sel),
      .target  (iEX_branch_target),
      .pc      (pc)
   );

   // A branch pulse is ignored only while still in IDLE after reset.
   assign redirect = iEX_branch_taken && (state != IDLE);

   // Next-state, pc selection and request generation.
   always_comb begin
      state_next  = state;
      pc_sel      = PC_KEEP;
      req         = 1'b0;
      addr        = pc;
      capture     = 1'b0;
      clear_valid = 1'b0;
      drain_load  = 1'b0;
      case (state)
         IDLE: begin
            state_next = FETCH;
         end
         FETCH: begin
            req = 1'b1;
            if (redirect) begin
               pc_sel      = PC_LOAD;
               clear_valid = 1'b1;
               if (im.iIM_ack) begin
                  state_next = FETCH;
               end else begin
                  // Outstanding request: its response must be swallowed.
                  state_next = DRAIN;
                  drain_load = 1'b1;
               end
            end else if (im.iIM_ack) begin
               capture = 1'b1;
               if (hazard) begin
                  state_next = HOLD;
               end else begin
                  pc_sel = PC_INC;
               end
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_sel      = PC_LOAD;
               clear_valid = 1'b1;
               state_next  = FETCH;
            end else if (!hazard) begin
               pc_sel     = PC_INC;
               state_next = FETCH;
            end
         end
         DRAIN: begin
            req  = 1'b1;
            addr = drain_addr;
            if (redirect) begin
               pc_sel      = PC_LOAD;
               clear_valid = 1'b1;
            end
            if (im.iIM_ack) begin
               state_next = FETCH;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Captured instruction, its pc, the valid flag and the drained address.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         inst_q     <= NOP_WORD;
         pc_q       <= RESET_PC;
         valid      <= 1'b0;
         drain_addr <= RESET_PC;
      end else begin
         if (capture) begin
            inst_q <= im.iIM_rdata;
            pc_q   <= pc;
            valid  <= 1'b1;
         end else if (clear_valid) begin
            valid <= 1'b0;
         end
         if (drain_load) begin
            drain_addr <= pc;
         end
      end
   end

   assign im.oIM_req      = req;
   assign im.oIM_addr     = addr;
   assign oIF_instruction = valid ? inst_q : NOP_WORD;
   assign oIF_current_pc  = pc_q;
   assign do_flush_REG1   = redirect;
   assign do_flush_REG2   = redirect;
   assign dbg_state       = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic         clock;
   logic         reset_n;
   logic         iEX_branch_taken;
   logic [9:0]   iEX_branch_target;
   logic         hazard;
   logic [31:0]  oIF_instruction;
   logic [9:0]   oIF_current_pc;
   logic         do_flush_REG1;
   logic         do_flush_REG2;
   fetch_state_e dbg_state;

   int errors = 0;
   int checks = 0;

   fetch_unit_if #(.PC_WIDTH(10)) im_bus ();

   fetch_unit #(
      .PC_WIDTH (10),
      .RESET_PC (10'd0),
      .NOP_WORD (32'h0000_0000)
   ) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .im                (im_bus),
      .iEX_branch_taken  (iEX_branch_taken),
      .iEX_branch_target (iEX_branch_target),
      .hazard            (hazard),
      .oIF_instruction   (oIF_instruction),
      .oIF_current_pc    (oIF_current_pc),
      .do_flush_REG1     (do_flush_REG1),
      .do_flush_REG2     (do_flush_REG2),
      .dbg_state         (dbg_state)
   );

   // Clock generation.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic ack, input logic [31:0] rd, input logic br,
                        input logic [9:0] tgt, input logic hz);
      im_bus.iIM_ack    = ack;
      im_bus.iIM_rdata  = rd;
      iEX_branch_taken  = br;
      iEX_branch_target = tgt;
      hazard            = hz;
      #1;
   endtask

   task automatic tick;
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      reset_n = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 10'h0, 1'b0);
      @(negedge clock);
      #1;
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      chk("rst_req", 32'(im_bus.oIM_req), 32'd0);
      chk("rst_addr", 32'(im_bus.oIM_addr), 32'd0);
      chk("rst_instr", oIF_instruction, 32'h0);
      chk("rst_cur_pc", 32'(oIF_current_pc), 32'd0);
      chk("rst_flush1", 32'(do_flush_REG1), 32'd0);
      chk("rst_flush2", 32'(do_flush_REG2), 32'd0);

      // Release reset; a branch pulse during IDLE is ignored.
      reset_n = 1'b1;
      drive(1'b0, 32'h0, 1'b1, 10'h055, 1'b0);
      chk("idle_state", 32'(dbg_state), 32'(IDLE));
      chk("idle_req", 32'(im_bus.oIM_req), 32'd0);
      chk("idle_br_flush", 32'(do_flush_REG1), 32'd0);
      tick();

      // Zero-wait stream, words 0x11.. at addresses 0..
      drive(1'b1, 32'h11, 1'b0, 10'h0, 1'b0);
      chk("first_req", 32'(im_bus.oIM_req), 32'd1);
      chk("first_addr", 32'(im_bus.oIM_addr), 32'd0);
      chk("first_state", 32'(dbg_state), 32'(FETCH));
      tick();
      drive(1'b1, 32'h12, 1'b0, 10'h0, 1'b0);
      chk("s0_instr", oIF_instruction, 32'h11);
      chk("s0_pc", 32'(oIF_current_pc), 32'd0);
      chk("s0_addr", 32'(im_bus.oIM_addr), 32'd1);
      tick();
      drive(1'b1, 32'h13, 1'b0, 10'h0, 1'b0);
      chk("s1_instr", oIF_instruction, 32'h12);
      chk("s1_pc", 32'(oIF_current_pc), 32'd1);
      chk("s1_addr", 32'(im_bus.oIM_addr), 32'd2);
      tick();
      drive(1'b1, 32'h14, 1'b0, 10'h0, 1'b0);
      chk("s2_instr", oIF_instruction, 32'h13);
      chk("s2_pc", 32'(oIF_current_pc), 32'd2);
      tick();
      drive(1'b1, 32'h15, 1'b0, 10'h0, 1'b0);
      chk("s3_instr", oIF_instruction, 32'h14);
      chk("s3_pc", 32'(oIF_current_pc), 32'd3);
      chk("s3_addr", 32'(im_bus.oIM_addr), 32'd4);
      tick();

      // Hazard for two cycles while the address-5 word is captured/held.
      drive(1'b1, 32'h16, 1'b0, 10'h0, 1'b1);
      chk("s4_instr", oIF_instruction, 32'h15);
      chk("s4_addr", 32'(im_bus.oIM_addr), 32'd5);
      tick();
      drive(1'b0, 32'h0, 1'b0, 10'h0, 1'b1);
      chk("hold_state", 32'(dbg_state), 32'(HOLD));
      chk("hold_req", 32'(im_bus.oIM_req), 32'd0);
      chk("hold_instr", oIF_instruction, 32'h16);
      chk("hold_pc", 32'(oIF_current_pc), 32'd5);
      tick();
      drive(1'b0, 32'h0, 1'b0, 10'h0, 1'b0);
      chk("hold2_state", 32'(dbg_state), 32'(HOLD));
      chk("hold2_instr", oIF_instruction, 32'h16);
      tick();
      drive(1'b0, 32'h0, 1'b0, 10'h0, 1'b0);
      chk("unhold_req", 32'(im_bus.oIM_req), 32'd1);
      chk("unhold_addr", 32'(im_bus.oIM_addr), 32'd6);
      chk("unhold_instr", oIF_instruction, 32'h16);
      tick();

      // Branch during an outstanding wait-state request.
      drive(1'b0, 32'h0, 1'b0, 10'h0, 1'b0);
      chk("wait_addr", 32'(im_bus.oIM_addr), 32'd6);
      chk("wait_flush", 32'(do_flush_REG1), 32'd0);
      tick();
      drive(1'b0, 32'h0, 1'b1, 10'h200, 1'b0);
      chk("br_flush1", 32'(do_flush_REG1), 32'd1);
      chk("br_flush2", 32'(do_flush_REG2), 32'd1);
      tick();
      drive(1'b0, 32'h0, 1'b0, 10'h0, 1'b0);
      chk("drain_state", 32'(dbg_state), 32'(DRAIN));
      chk("drain_req", 32'(im_bus.oIM_req), 32'd1);
      chk("drain_addr", 32'(im_bus.oIM_addr), 32'd6);
      chk("drain_instr", oIF_instruction, 32'h0);
      chk("drain_flush", 32'(do_flush_REG1), 32'd0);
      tick();
      drive(1'b1, 32'hDEAD, 1'b0, 10'h0, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 10'h0, 1'b0);
      chk("postdrain_state", 32'(dbg_state), 32'(FETCH));
      chk("postdrain_addr", 32'(im_bus.oIM_addr), 32'h200);
      chk("postdrain_instr", oIF_instruction, 32'h0);
      tick();
      drive(1'b1, 32'h77, 1'b0, 10'h0, 1'b0);
      tick();

      // Branch plus hazard in the ack cycle: word discarded, no HOLD.
      drive(1'b1, 32'h99, 1'b1, 10'h3FF, 1'b1);
      chk("tgt_instr", oIF_instruction, 32'h77);
      chk("tgt_pc", 32'(oIF_current_pc), 32'h200);
      chk("bha_flush", 32'(do_flush_REG2), 32'd1);
      tick();
      drive(1'b1, 32'hA0, 1'b0, 10'h0, 1'b0);
      chk("bha_state", 32'(dbg_state), 32'(FETCH));
      chk("bha_addr", 32'(im_bus.oIM_addr), 32'h3FF);
      chk("bha_instr", oIF_instruction, 32'h0);
      chk("bha_cur_pc", 32'(oIF_current_pc), 32'h200);
      tick();

      // PC wrap from 1023 to 0.
      drive(1'b1, 32'hA1, 1'b0, 10'h0, 1'b0);
      chk("wrap_instr", oIF_instruction, 32'hA0);
      chk("wrap_pc", 32'(oIF_current_pc), 32'h3FF);
      chk("wrap_addr", 32'(im_bus.oIM_addr), 32'd0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 10'h0, 1'b0);
      chk("wrap2_instr", oIF_instruction, 32'hA1);
      chk("wrap2_pc", 32'(oIF_current_pc), 32'd0);
      chk("wrap2_addr", 32'(im_bus.oIM_addr), 32'd1);
      tick();

      // Second redirect while draining overwrites the target.
      drive(1'b0, 32'h0, 1'b1, 10'h010, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b1, 10'h020, 1'b0);
      chk("dr2_state", 32'(dbg_state), 32'(DRAIN));
      chk("dr2_flush", 32'(do_flush_REG1), 32'd1);
      tick();
      drive(1'b1, 32'hBAD, 1'b0, 10'h0, 1'b0);
      chk("dr2_state2", 32'(dbg_state), 32'(DRAIN));
      chk("dr2_addr", 32'(im_bus.oIM_addr), 32'd1);
      tick();
      drive(1'b1, 32'hC3, 1'b0, 10'h0, 1'b0);
      chk("dr2_new_addr", 32'(im_bus.oIM_addr), 32'h020);
      chk("dr2_instr", oIF_instruction, 32'h0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 10'h0, 1'b0);
      chk("c3_instr", oIF_instruction, 32'hC3);
      chk("c3_pc", 32'(oIF_current_pc), 32'h020);
      chk("c3_addr", 32'(im_bus.oIM_addr), 32'h021);

      // Asynchronous reset in the middle of a wait.
      drive(1'b0, 32'h0, 1'b1, 10'h155, 1'b0);
      reset_n = 1'b0;
      #1;
      chk("arst_state", 32'(dbg_state), 32'(IDLE));
      chk("arst_req", 32'(im_bus.oIM_req), 32'd0);
      chk("arst_addr", 32'(im_bus.oIM_addr), 32'd0);
      chk("arst_instr", oIF_instruction, 32'h0);
      chk("arst_pc", 32'(oIF_current_pc), 32'd0);
      chk("arst_flush", 32'(do_flush_REG1), 32'd0);
      drive(1'b0, 32'h0, 1'b0, 10'h0, 1'b0);
      tick();
      reset_n = 1'b1;
      drive(1'b1, 32'hEE, 1'b0, 10'h0, 1'b0);
      chk("rel_state", 32'(dbg_state), 32'(IDLE));
      tick();
      drive(1'b0, 32'h0, 1'b0, 10'h0, 1'b0);
      chk("rel_req", 32'(im_bus.oIM_req), 32'd1);
      chk("rel_addr", 32'(im_bus.oIM_addr), 32'd0);
      chk("rel_instr", oIF_instruction, 32'h0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the pipeline register bank.
- Owns the program counter and runs a req/ack handshake to instruction memory.
- Presents the fetched instruction and its PC to the REG1 wall.
- Holds its output while a hazard stalls the pipe, and redirects on a taken branch, generating the REG1/REG2 flush requests.

Parameters:
- PC_WIDTH, 10, word-address width of the PC and the instruction-memory address.
- RESET_PC, 0, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction presented when no valid fetch is held; matches the flushed-wall value.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- oIM_req  out  1  instruction-memory request.
- oIM_addr  out  PC_WIDTH  word address; stable while oIM_req=1 and not acked.
- iIM_ack  in  1  one-cycle acknowledge; iIM_rdata valid in that cycle.
- iIM_rdata  in  32  fetched instruction word.
- iEX_branch_taken  in  1  one-cycle redirect pulse from execute.
- iEX_branch_target  in  PC_WIDTH  redirect word address.
- hazard  in  1  load-use stall from the hazard logic; same signal that zeroes REG2.
- oIF_instruction  out  32  to REG1 instruction input.
- oIF_current_pc  out  PC_WIDTH  PC of oIF_instruction; to REG1 current-PC input.
- do_flush_REG1  out  1  flush request to the walls.
- do_flush_REG2  out  1  flush request to the walls.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, pc=RESET_PC, valid=0.
  - oIM_req=0, oIM_addr=RESET_PC.
  - oIF_instruction=NOP_WORD, oIF_current_pc=RESET_PC.
  - Both flush outputs 0.
  - Reset asserted mid-handshake abandons the request; no ack is tracked after release.
- States:
  - IDLE: one cycle after reset release, then FETCH.
  - FETCH: oIM_req=1, oIM_addr=pc.
  - HOLD: oIM_req=0; waiting for the stall to clear.
  - DRAIN: oIM_req=1, old address held; discards the response after a redirect.
- FETCH, no ack: stay in FETCH; address held constant.
- FETCH, iIM_ack=1, no redirect:
  - inst_q<=iIM_rdata, pc_q<=pc, valid<=1.
  - If hazard=0: pc<=pc+1, stay in FETCH (back-to-back fetch; 1 instruction per cycle with zero-wait memory).
  - If hazard=1: pc unchanged, go to HOLD.
- FETCH, hazard=1 without ack: keep requesting; the ack is taken as above.
- HOLD:
  - Outputs frozen.
  - When hazard=0: pc<=pc+1, go to FETCH.
- Redirect (iEX_branch_taken=1) has priority over hazard and ack, from any state except IDLE:
  - pc<=iEX_branch_target, valid<=0.
  - do_flush_REG1=do_flush_REG2=1 for exactly that cycle (combinational from the pulse, registered by the walls).
  - If oIM_req=1 and iIM_ack=0: go to DRAIN.
  - Otherwise go to FETCH; a same-cycle ack is discarded.
- DRAIN:
  - On iIM_ack, discard the data and go to FETCH at the new pc.
  - A second redirect during DRAIN overwrites pc and stays in DRAIN.
- Outputs:
  - oIF_instruction = valid ? inst_q : NOP_WORD.
  - oIF_current_pc = pc_q.
  - Latency: ack cycle -> next posedge output.
- PC arithmetic: modulo 2^PC_WIDTH; 1023+1 wraps to 0 with no flag.
- A redirect arriving in the same cycle as reset release is ignored (IDLE).

Decomposition:
- Shared package: fetch state encoding (IDLE/FETCH/HOLD/DRAIN), NOP_WORD, PC_WIDTH default.
- One sub-module is natural: fetch_pc_gen, holding the pc register plus next-pc mux (target / pc+1 / hold).
- FSM and output registers stay in fetch_unit.

Test Plan:
- Reset, then zero-wait memory (ack every request cycle), words 0x11..0x14 at addresses 0..3 -> oIF_instruction 0x11,0x12,0x13,0x14 on consecutive cycles with oIF_current_pc 0,1,2,3; oIM_req first high one cycle after release.
- hazard high 2 cycles while the word at address 5 is held -> output stays at the address-5 word, oIM_req=0 in HOLD, address 6 requested the cycle after hazard falls.
- Branch pulse, target=0x200, during an outstanding 3-wait request -> flush pulses 1 cycle; DRAIN consumes the stale ack; next oIM_addr=0x200; output NOP until the 0x200 word arrives.
- Branch pulse and hazard in the same cycle as iIM_ack -> acked word discarded, pc=target, state FETCH, no HOLD entry.
- pc=1023 fetch with zero-wait memory -> next oIM_addr=0, oIF_current_pc sequence 1023,0.
- reset_n low mid-wait -> all outputs return to reset values asynchronously; after release the first request goes to RESET_PC.
